intersection_phase_scheduler: RTL
=================================

Name: intersection_phase_scheduler

Overview:
- Sequences a two-road intersection (main road, side road) plus a pedestrian crossing.
- Drives both signal heads and the walk lamp.
- Arbitrates the green between side-road vehicle demand and latched pedestrian requests.
- Main road rests on green with no demand. Every phase has a minimum time, and the side road has a maximum, so no requester starves.

Parameters:
CNT_W, 8, phase timer width; every duration below must be <= 2^CNT_W
MIN_GREEN, 10, minimum green cycles for either road (>=1)
MAX_GREEN, 30, maximum side-road green cycles (>=MIN_GREEN)
YELLOW_T, 3, yellow cycles (>=1)
ALL_RED_T, 2, all-red clearance cycles (>=1)
WALK_T, 8, pedestrian walk cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
side_req  input  1  side-road vehicle sensor, level
ped_req  input  1  pedestrian button, pulse or level; latched internally
light_main  output  3  main head {Red,Yellow,Green}, one-hot
light_side  output  3  side head {Red,Yellow,Green}, one-hot
walk  output  1  walk lamp, high only in PED_WALK
ped_ack  output  1  one-cycle pulse on first PED_WALK cycle
phase  output  3  current state encoding (debug)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ALL_RED_2, timer=0, ped_pending=0.
  - light_main=100, light_side=100, walk=0, ped_ack=0.
  - Applies immediately, mid-phase included.
- Moore outputs, decoded from the state register only:
  - Any state except MAIN_* drives light_main=100.
  - Any state except SIDE_* drives light_side=100.
  - Both heads are never non-red together.
- State encoding (phase):
  - MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5, PED_WALK=6.
  - Code 7 is illegal and recovers to ALL_RED_2 next cycle.
- Timer:
  - Cleared to 0 on the cycle a state is entered.
  - Increments each cycle thereafter and saturates at 2^CNT_W-1 (no wrap).
  - "Elapsed(N)" means timer==N-1 or greater, so a state lasts at least N cycles.
- Transitions (evaluated every cycle; registered on next edge):
  - MAIN_GREEN (main 001): after Elapsed(MIN_GREEN), exit to MAIN_YELLOW if side_req or ped_pending. With no demand, stay indefinitely.
  - MAIN_YELLOW (main 010): after Elapsed(YELLOW_T), go to ALL_RED_1.
  - ALL_RED_1: after Elapsed(ALL_RED_T), go to PED_WALK if ped_pending, else SIDE_GREEN. The pedestrian is served before the side road.
  - SIDE_GREEN (side 001): after Elapsed(MIN_GREEN), exit to SIDE_YELLOW if side_req==0 or ped_pending. At Elapsed(MAX_GREEN), exit unconditionally.
  - SIDE_YELLOW (side 010): after Elapsed(YELLOW_T), go to ALL_RED_2.
  - PED_WALK: walk=1, both heads red. After Elapsed(WALK_T), go to ALL_RED_2.
  - ALL_RED_2: after Elapsed(ALL_RED_T), go to MAIN_GREEN.
- ped_pending:
  - Set on any cycle with ped_req=1, except while state==PED_WALK, where requests are dropped.
  - Cleared on the transition into PED_WALK; clear wins over a simultaneous ped_req.
- ped_ack: registered pulse, high exactly on the first cycle in PED_WALK.
- side_req is sampled only at exit decisions. A side_req pulse that ends before MAIN_GREEN's minimum is lost; this is intended, since the sensor is level.
- After reset release: ALL_RED_2 for ALL_RED_T cycles, then MAIN_GREEN.

Test Plan:
- Release reset, inputs 0 → both heads 100 for 2 cycles, then light_main=001, light_side=100 held for 100 cycles; walk=0, ped_ack=0 throughout.
- side_req held 1 from reset release → main green exactly 10 cycles, main 010 for 3, all-red 2, side 001 for exactly 30 (MAX), side 010 for 3, all-red 2, main 001 again.
- side_req high only after main green has run 20 cycles → MAIN_YELLOW on next cycle.
  - In side green, drop side_req at the 4th side-green cycle → side green lasts exactly 10 cycles (MIN).
- One-cycle ped_req at main-green cycle 2, side_req=1 → main green 10, yellow 3, all-red 2, walk=1 for 8 cycles (ped_ack on the first only, heads 100/100), all-red 2, main green 10, then the side sequence.
- ped_req held during the whole PED_WALK (ped_pending was 1) → ped_pending 0 afterwards. Main green stays indefinitely with side_req=0.
- Assert reset at side-green cycle 5 with ped_pending=1 → same-cycle light_side=100, light_main=100, walk=0, phase=5.
  - After release, the sequence runs as in the first scenario; no walk is served.

Source files
------------

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
// Phase sequencer for a main road, a side road and a pedestrian crossing.
// The main road rests on green. Side-road demand and latched pedestrian
// requests pull the green away after a minimum time. The side road is also
// capped at a maximum green, so no requester can starve.
// The outputs are registered Moore decodes of the next state, so they always
// track the state register with no extra latency.

module intersection_phase_scheduler #(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int WALK_T    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [2:0] ST_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] ST_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] ST_ALL_RED_1   = 3'd2;
  localparam logic [2:0] ST_SIDE_GREEN  = 3'd3;
  localparam logic [2:0] ST_SIDE_YELLOW = 3'd4;
  localparam logic [2:0] ST_ALL_RED_2   = 3'd5;
  localparam logic [2:0] ST_PED_WALK    = 3'd6;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // An Elapsed(N) check is true once the timer has reached N-1.
  localparam logic [CNT_W-1:0] MIN_GREEN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_GREEN_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALL_RED_M1   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] WALK_M1      = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX    = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_ped_pending;
  logic [2:0]       r_light_main;
  logic [2:0]       r_light_side;
  logic             r_walk;
  logic             r_ped_ack;

  logic [2:0]       w_state_next;
  logic             w_enter_walk;
  logic             w_ped_pending_next;
  logic [2:0]       w_light_main_next;
  logic [2:0]       w_light_side_next;
  logic             w_walk_next;

  // The phase timer restarts on every state change and saturates instead of wrapping.
  // The pedestrian latch is cleared on entry to the walk phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_ALL_RED_2;
      r_timer       <= {CNT_W{1'b0}};
      r_ped_pending <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ped_pending <= w_ped_pending_next;
      if (w_state_next != r_state) begin
        r_timer <= {CNT_W{1'b0}};
      end else if (r_timer != TIMER_MAX) begin
        r_timer <= r_timer + CNT_W'(1);
      end else begin
        r_timer <= r_timer;
      end
    end
  end

  // Next-state logic: minimum and maximum phase times, demand arbitration, recovery from code 7.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_MAIN_GREEN: begin
        if ((r_timer >= MIN_GREEN_M1) && (side_req || r_ped_pending)) begin
          w_state_next = ST_MAIN_YELLOW;
        end else begin
          w_state_next = ST_MAIN_GREEN;
        end
      end
      ST_MAIN_YELLOW: begin
        if (r_timer >= YELLOW_M1) begin
          w_state_next = ST_ALL_RED_1;
        end else begin
          w_state_next = ST_MAIN_YELLOW;
        end
      end
      ST_ALL_RED_1: begin
        // The pedestrian is served ahead of the side road.
        if (r_timer >= ALL_RED_M1) begin
          w_state_next = r_ped_pending ? ST_PED_WALK : ST_SIDE_GREEN;
        end else begin
          w_state_next = ST_ALL_RED_1;
        end
      end
      ST_SIDE_GREEN: begin
        if (r_timer >= MAX_GREEN_M1) begin
          w_state_next = ST_SIDE_YELLOW;
        end else if ((r_timer >= MIN_GREEN_M1) && (!side_req || r_ped_pending)) begin
          w_state_next = ST_SIDE_YELLOW;
        end else begin
          w_state_next = ST_SIDE_GREEN;
        end
      end
      ST_SIDE_YELLOW: begin
        if (r_timer >= YELLOW_M1) begin
          w_state_next = ST_ALL_RED_2;
        end else begin
          w_state_next = ST_SIDE_YELLOW;
        end
      end
      ST_ALL_RED_2: begin
        if (r_timer >= ALL_RED_M1) begin
          w_state_next = ST_MAIN_GREEN;
        end else begin
          w_state_next = ST_ALL_RED_2;
        end
      end
      ST_PED_WALK: begin
        if (r_timer >= WALK_M1) begin
          w_state_next = ST_ALL_RED_2;
        end else begin
          w_state_next = ST_PED_WALK;
        end
      end
      default: begin
        w_state_next = ST_ALL_RED_2;
      end
    endcase
  end

  // Pedestrian latch: a clear on walk entry wins over a request; requests during the walk are dropped.
  always_comb begin
    w_enter_walk       = (w_state_next == ST_PED_WALK) && (r_state != ST_PED_WALK);
    w_ped_pending_next = r_ped_pending;
    if (w_enter_walk) begin
      w_ped_pending_next = 1'b0;
    end else if (ped_req && (r_state != ST_PED_WALK)) begin
      w_ped_pending_next = 1'b1;
    end else begin
      w_ped_pending_next = r_ped_pending;
    end
  end

  // Output decode of the upcoming state. Each head is red outside its own phases.
  always_comb begin
    w_light_main_next = LAMP_RED;
    w_light_side_next = LAMP_RED;
    w_walk_next       = 1'b0;
    case (w_state_next)
      ST_MAIN_GREEN:  w_light_main_next = LAMP_GREEN;
      ST_MAIN_YELLOW: w_light_main_next = LAMP_YELLOW;
      ST_SIDE_GREEN:  w_light_side_next = LAMP_GREEN;
      ST_SIDE_YELLOW: w_light_side_next = LAMP_YELLOW;
      ST_PED_WALK:    w_walk_next       = 1'b1;
      default: begin
        w_light_main_next = LAMP_RED;
        w_light_side_next = LAMP_RED;
        w_walk_next       = 1'b0;
      end
    endcase
  end

  // Output registers. Reset forces all-red immediately, including in the middle of a phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_light_main <= LAMP_RED;
      r_light_side <= LAMP_RED;
      r_walk       <= 1'b0;
      r_ped_ack    <= 1'b0;
    end else begin
      r_light_main <= w_light_main_next;
      r_light_side <= w_light_side_next;
      r_walk       <= w_walk_next;
      r_ped_ack    <= w_enter_walk;
    end
  end

  assign light_main = r_light_main;
  assign light_side = r_light_side;
  assign walk       = r_walk;
  assign ped_ack    = r_ped_ack;
  assign phase      = r_state;

endmodule
